shaper_event_ctrl: RTL and testbench



---
 rtl/shaper_event_ctrl_if.sv | 28 ++
 rtl/shaper_event_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_shaper_event_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/shaper_event_ctrl_if.sv
// Event delivery channel from the shaper sequencer to downstream logic:
// one event slot with a valid/ready handshake.
interface shaper_event_ctrl_if #(
    parameter int DATA_W = 26,
    parameter int TS_W   = 32
);
    logic                     ev_valid;
    logic                     ev_ready;
    logic signed [DATA_W-1:0] ev_amp;
    logic        [TS_W-1:0]   ev_time;
    logic                     ev_pileup;

    modport master (
        output ev_valid,
        input  ev_ready,
        output ev_amp,
        output ev_time,
        output ev_pileup
    );

    modport slave (
        input  ev_valid,
        output ev_ready,
        input  ev_amp,
        input  ev_time,
        input  ev_pileup
    );
endinterface

// File: rtl/shaper_event_ctrl.sv
// Sequencer / event scheduler for a trapezoidal shaping filter: flushes the
// filter, arms on a threshold crossing, samples the flat-top amplitude,
// classifies pile-up and hands one event at a time to the consumer.
module shaper_event_ctrl #(
    parameter int DATA_W   = 26,
    parameter int K_LEN    = 4,
    parameter int L_LEN    = 8,
    parameter int DEAD_LEN = 12,
    parameter int TS_W     = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic signed [DATA_W-1:0] threshold,
    input  logic signed [DATA_W-1:0] filt_data,
    output logic                     filt_reset_n,
    shaper_event_ctrl_if.master      ev,
    output logic [15:0]              drop_cnt,
    output logic                     busy
);
    localparam int FLT_LEN = K_LEN + L_LEN + 2;
    localparam int FT_OFF  = (L_LEN - K_LEN) / 2;

    typedef enum logic [2:0] {S_FLUSH, S_IDLE, S_RISE, S_PEAK, S_DEAD} state_t;

    state_t                   state_q, state_d;
    logic [15:0]              cnt_q, cnt_d;
    logic [TS_W-1:0]          ts_q, ts_d;
    logic [TS_W-1:0]          ts_hold_q, ts_hold_d;
    logic signed [DATA_W-1:0] amp_hold_q, amp_hold_d;
    logic                     pu_q, pu_d;
    logic                     ev_valid_q, ev_valid_d;
    logic signed [DATA_W-1:0] ev_amp_q, ev_amp_d;
    logic [TS_W-1:0]          ev_time_q, ev_time_d;
    logic                     ev_pileup_q, ev_pileup_d;
    logic [15:0]              drop_q, drop_d;

    logic                     above_thr;
    logic                     spike;
    logic                     pu_now;
    logic                     load;
    logic signed [DATA_W:0]   filt_ext;
    logic signed [DATA_W:0]   spike_lvl;

    // Next-state, event timing, pile-up classification and slot management
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ts_d        = ts_q + 1'b1;
        ts_hold_d   = ts_hold_q;
        amp_hold_d  = amp_hold_q;
        pu_d        = pu_q;
        ev_valid_d  = ev_valid_q;
        ev_amp_d    = ev_amp_q;
        ev_time_d   = ev_time_q;
        ev_pileup_d = ev_pileup_q;
        drop_d      = drop_q;
        load        = 1'b0;
        pu_now      = pu_q;

        above_thr = filt_data > threshold;
        // One extra bit so amp_hold + threshold cannot overflow
        filt_ext  = {filt_data[DATA_W-1], filt_data};
        spike_lvl = $signed({amp_hold_q[DATA_W-1], amp_hold_q})
                  + $signed({threshold[DATA_W-1], threshold});
        spike     = filt_ext > spike_lvl;

        case (state_q)
            S_FLUSH: begin
                if (cnt_q == 16'(FLT_LEN - 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_IDLE: begin
                cnt_d = '0;
                pu_d  = 1'b0;
                if (enable && above_thr) begin
                    ts_hold_d = ts_q;
                    state_d   = S_RISE;
                end
            end
            S_RISE: begin
                if (!above_thr) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == 16'(K_LEN - 1)) begin
                    cnt_d = '0;
                    if (FT_OFF == 0) begin
                        amp_hold_d = filt_data;
                        state_d    = S_DEAD;
                    end else begin
                        state_d = S_PEAK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_PEAK: begin
                if (!above_thr) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == 16'(FT_OFF - 1)) begin
                    amp_hold_d = filt_data;
                    state_d    = S_DEAD;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DEAD: begin
                pu_now = pu_q | spike;
                if (cnt_q == 16'(DEAD_LEN - 1)) begin
                    pu_now  = pu_now | above_thr;
                    load    = 1'b1;
                    state_d = pu_now ? S_FLUSH : S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                pu_d = pu_now;
            end
            default: begin
                state_d = S_FLUSH;
                cnt_d   = '0;
            end
        endcase

        // Accept and load in the same cycle is allowed, so the slot never bubbles
        if (load) begin
            if (!ev_valid_q || ev.ev_ready) begin
                ev_valid_d  = 1'b1;
                ev_amp_d    = amp_hold_q;
                ev_time_d   = ts_hold_q;
                ev_pileup_d = pu_now;
            end else if (drop_q != 16'hFFFF) begin
                drop_d = drop_q + 1'b1;
            end
        end else if (ev_valid_q && ev.ev_ready) begin
            ev_valid_d = 1'b0;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_FLUSH;
            cnt_q       <= '0;
            ts_q        <= '0;
            ts_hold_q   <= '0;
            amp_hold_q  <= '0;
            pu_q        <= 1'b0;
            ev_valid_q  <= 1'b0;
            ev_amp_q    <= '0;
            ev_time_q   <= '0;
            ev_pileup_q <= 1'b0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ts_q        <= ts_d;
            ts_hold_q   <= ts_hold_d;
            amp_hold_q  <= amp_hold_d;
            pu_q        <= pu_d;
            ev_valid_q  <= ev_valid_d;
            ev_amp_q    <= ev_amp_d;
            ev_time_q   <= ev_time_d;
            ev_pileup_q <= ev_pileup_d;
            drop_q      <= drop_d;
        end
    end

    assign filt_reset_n = (state_q != S_FLUSH);
    assign busy         = (state_q != S_IDLE);
    assign drop_cnt     = drop_q;
    assign ev.ev_valid  = ev_valid_q;
    assign ev.ev_amp    = ev_amp_q;
    assign ev.ev_time   = ev_time_q;
    assign ev.ev_pileup = ev_pileup_q;
endmodule

// File: tb/tb_shaper_event_ctrl.sv
// Directed testbench for shaper_event_ctrl (K=4, L=8, DEAD=12).
module tb_shaper_event_ctrl;
    localparam int DW = 26;
    localparam int TW = 32;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 enable;
    logic signed [DW-1:0] threshold;
    logic signed [DW-1:0] filt_data;
    logic                 filt_reset_n;
    logic [15:0]          drop_cnt;
    logic                 busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    shaper_event_ctrl_if #(.DATA_W(DW), .TS_W(TW)) ev_if ();

    shaper_event_ctrl #(
        .DATA_W(DW), .K_LEN(4), .L_LEN(8), .DEAD_LEN(12), .TS_W(TW)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .threshold(threshold),
        .filt_data(filt_data), .filt_reset_n(filt_reset_n), .ev(ev_if.master),
        .drop_cnt(drop_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    // Advance one cycle; inputs and observations live 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Pulse shape by offset from the crossing cycle T
    function automatic int wave(int off, int flat, bit spk);
        if (off == 0) return flat / 2;
        if (off <= 6) return flat;
        if (off <= 16) return (spk && off >= 10 && off <= 12) ? 2500 : flat / 2;
        return 0;
    endfunction

    // Drives windows T..T+18 and returns in window T+18 (the load cycle)
    task automatic drive_pulse(input int flat, input bit spk, input logic rdy_pre,
                               input logic rdy_load, output int t_ts);
        t_ts = cyc;
        for (int off = 0; off <= 18; off++) begin
            filt_data      = DW'(wave(off, flat, spk));
            ev_if.ev_ready = (off == 18) ? rdy_load : rdy_pre;
            if (off < 18) tick();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        enable = 1'b1; threshold = 100; filt_data = 0; ev_if.ev_ready = 1'b0;
        do_reset();
        checks++;
        if (ev_if.ev_valid !== 1'b0 || drop_cnt !== 16'd0 || ev_if.ev_amp !== '0 ||
            ev_if.ev_time !== '0 || ev_if.ev_pileup !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: valid=%b drop=%0d amp=%0d time=%0d pu=%b required all 0",
                     ev_if.ev_valid, drop_cnt, ev_if.ev_amp, ev_if.ev_time, ev_if.ev_pileup);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 14; i++) begin
            checks++;
            if (filt_reset_n !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL flush_cycle%0d: filt_reset_n=%b busy=%b required 0/1",
                         i, filt_reset_n, busy);
            end
            tick();
        end
        checks++;
        if (filt_reset_n !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_end: filt_reset_n=%b busy=%b required 1/0", filt_reset_n, busy);
        end
    endtask

    task automatic test_clean_pulse();
        int t;
        drive_pulse(1000, 1'b0, 1'b1, 1'b1, t);
        checks++;
        if (ev_if.ev_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL clean_T18: valid=%b busy=%b required 0/1", ev_if.ev_valid, busy);
        end
        tick();
        checks++;
        if (ev_if.ev_valid !== 1'b1 || ev_if.ev_amp !== DW'(1000) ||
            ev_if.ev_time !== TW'(t) || ev_if.ev_pileup !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL clean_event: valid=%b amp=%0d time=%0d pu=%b busy=%b required 1/1000/%0d/0/0",
                     ev_if.ev_valid, ev_if.ev_amp, ev_if.ev_time, ev_if.ev_pileup, busy, t);
        end
        tick();
        checks++;
        if (ev_if.ev_valid !== 1'b0) begin
            errors++;
            $display("FAIL clean_accept: valid=%b required 0", ev_if.ev_valid);
        end
    endtask

    task automatic test_noise();
        int seen = 0;
        filt_data = 100;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL equal_threshold: busy=%b required 0", busy);
            end
        end
        filt_data = 150;
        tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL glitch_arm: busy=%b required 1", busy);
        end
        tick();
        filt_data = 0;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL glitch_abort: busy=%b required 0", busy);
        end
        for (int i = 0; i < 22; i++) begin
            if (ev_if.ev_valid !== 1'b0) seen++;
            tick();
        end
        checks++;
        if (seen != 0 || drop_cnt !== 16'd0) begin
            errors++;
            $display("FAIL glitch_no_event: valid_cycles=%0d drop=%0d required 0/0", seen, drop_cnt);
        end
    endtask

    task automatic test_pileup();
        int t;
        int low = 0;
        drive_pulse(1000, 1'b1, 1'b1, 1'b1, t);
        tick();
        checks++;
        if (ev_if.ev_valid !== 1'b1 || ev_if.ev_amp !== DW'(1000) || ev_if.ev_pileup !== 1'b1 ||
            ev_if.ev_time !== TW'(t)) begin
            errors++;
            $display("FAIL pileup_event: valid=%b amp=%0d pu=%b time=%0d required 1/1000/1/%0d",
                     ev_if.ev_valid, ev_if.ev_amp, ev_if.ev_pileup, ev_if.ev_time, t);
        end
        for (int i = 0; i < 14; i++) begin
            if (filt_reset_n === 1'b0) low++;
            tick();
        end
        checks++;
        if (low != 14 || filt_reset_n !== 1'b1) begin
            errors++;
            $display("FAIL pileup_flush: low_cycles=%0d then %b required 14 then 1", low, filt_reset_n);
        end
    endtask

    task automatic test_back_to_back();
        int t1, t2, t3;
        drive_pulse(1000, 1'b0, 1'b0, 1'b0, t1);
        tick();
        drive_pulse(700, 1'b0, 1'b0, 1'b0, t2);
        tick();
        checks++;
        if (ev_if.ev_valid !== 1'b1 || ev_if.ev_amp !== DW'(1000) || ev_if.ev_time !== TW'(t1) ||
            drop_cnt !== 16'd1) begin
            errors++;
            $display("FAIL backpressure_drop: valid=%b amp=%0d time=%0d drop=%0d required 1/1000/%0d/1",
                     ev_if.ev_valid, ev_if.ev_amp, ev_if.ev_time, drop_cnt, t1);
        end
        drive_pulse(900, 1'b0, 1'b0, 1'b1, t3);
        tick();
        checks++;
        if (ev_if.ev_valid !== 1'b1 || ev_if.ev_amp !== DW'(900) || ev_if.ev_time !== TW'(t3) ||
            drop_cnt !== 16'd1) begin
            errors++;
            $display("FAIL accept_and_load: valid=%b amp=%0d time=%0d drop=%0d required 1/900/%0d/1",
                     ev_if.ev_valid, ev_if.ev_amp, ev_if.ev_time, drop_cnt, t3);
        end
        tick();
        checks++;
        if (ev_if.ev_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: valid=%b required 0", ev_if.ev_valid);
        end
    endtask

    task automatic test_reset_mid_dead();
        int t;
        int seen = 0;
        drive_pulse(800, 1'b0, 1'b0, 1'b0, t);
        tick();
        checks++;
        if (ev_if.ev_valid !== 1'b1 || drop_cnt !== 16'd1) begin
            errors++;
            $display("FAIL pre_reset_slot: valid=%b drop=%0d required 1/1", ev_if.ev_valid, drop_cnt);
        end
        for (int off = 0; off <= 10; off++) begin
            filt_data = DW'(wave(off, 800, 1'b0));
            if (off < 10) tick();
        end
        do_reset();
        checks++;
        if (ev_if.ev_valid !== 1'b0 || drop_cnt !== 16'd0 || filt_reset_n !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_dead: valid=%b drop=%0d frn=%b busy=%b required 0/0/0/1",
                     ev_if.ev_valid, drop_cnt, filt_reset_n, busy);
        end
        filt_data = 0;
        ev_if.ev_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (ev_if.ev_valid !== 1'b0) seen++;
            tick();
        end
        checks++;
        if (seen != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_quiet: valid_cycles=%0d busy=%b required 0/0", seen, busy);
        end
    endtask

    initial begin
        test_reset();
        test_flush();
        test_clean_pulse();
        test_noise();
        test_pileup();
        test_back_to_back();
        test_reset_mid_dead();
        test_clean_pulse();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
